mult_result_out_stage: RTL and testbench
========================================

Name: mult_result_out_stage

Overview:
Output end of the FPU multiplier datapath; the counterpart to the operand input registers at the front of the multiplier. Accepts the final sign, exponent and significand from the multiplier's last phase on a load strobe. Packs them into an IEEE-754 word, with overflow/underflow substitution, and holds up to two results in a 2-entry buffer. Drains the buffer to the downstream consumer over a valid/ready handshake so the multiplier FSM can start the next operation without waiting for the consumer.

Parameters:
W, 32, result word width (64 for double precision)
EW, 8, exponent width (11 for double)
SW, 23, stored significand width without the hidden bit (52 for double)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
load_res  in  1  one-cycle strobe from the multiplier FSM: present inputs are a finished result
sign_i  in  1  result sign
exp_i  in  EW  biased, already-normalised result exponent
sig_i  in  SW  rounded significand fraction
ovf_i  in  1  exponent overflow detected for this result
unf_i  in  1  exponent underflow detected for this result
in_ready  out  1  buffer can accept a load this cycle (registered: count<2)
res_valid  out  1  result/flags outputs hold a valid entry
res_ready  in  1  consumer accepts the head entry this cycle
result  out  W  packed IEEE word of the head entry
ovf_flag  out  1  overflow flag of the head entry
unf_flag  out  1  underflow flag of the head entry
drop_err  out  1  sticky: a load_res arrived while in_ready=0

Behaviour:
- Reset (rst=0, asynchronous) forces count=0, wr_ptr=0, rd_ptr=0, res_valid=0, in_ready=1, result=0, ovf_flag=0, unf_flag=0, drop_err=0. Buffer contents are don't-care. Reset mid-transfer discards all entries with no partial output.
- Packing is combinational before the write:
  - ovf_i=1: {sign_i, all-ones EW, zero SW} (signed infinity). ovf_i has priority when ovf_i and unf_i are both 1; both flags are stored as given.
  - unf_i=1, ovf_i=0: {sign_i, zeros} (signed zero).
  - Otherwise: {sign_i, exp_i, sig_i}.
- Storage: two W+2-bit entries {ovf, unf, word}, 1-bit wrap pointers, 2-bit count (0..2).
- push = load_res & in_ready. pop = res_valid & res_ready.
- Push writes entry[wr_ptr] and toggles wr_ptr. Pop toggles rd_ptr.
- count updates as follows:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- in_ready = (count != 2), derived from the registered count. There is no same-cycle pass-through when full: a load while full is refused even if a pop happens that cycle.
- load_res while in_ready=0: the data is dropped, no state changes except drop_err, which is set to 1 and held until reset.
- res_valid = (count != 0). result/ovf_flag/unf_flag show entry[rd_ptr] while res_valid=1. When res_valid=0 they read 0 (outputs are gated).
- Latency: a push at edge N into an empty buffer makes res_valid=1 with that result after edge N (1 cycle). Sustained throughput is one result per cycle when res_ready is held at 1.
- Outputs stay stable while res_valid=1 and res_ready=0. Entries drain in load order.
- Wrap-around: the pointers toggle freely, so ordering is preserved across any number of fill/drain cycles.
- res_ready while res_valid=0 has no effect.

Test Plan:
- Normal packing: reset, load sign=0 exp=0x7F sig=0x400000 ovf=0 unf=0, res_ready=1 -> next cycle res_valid=1, result=0x3FC00000; following cycle res_valid=0, result=0.
- Exceptions: load sign=1 ovf=1 (exp=0x12 sig=0x1) -> result=0xFF800000, ovf_flag=1. Load sign=1 unf=1 -> result=0x80000000, unf_flag=1. Load ovf=1 unf=1 sign=0 -> result=0x7F800000, both flags=1.
- Backpressure and full: res_ready=0, load A=0x3F800000 then B=0x40000000 -> in_ready=0 after the second edge. A third load C -> drop_err=1, C never appears. Then res_ready=1 -> outputs A, then B, then res_valid=0.
- Simultaneous push/pop: count=1 holding A, load B while res_ready=1 -> A pops, count stays 1, next head=B. Repeat 5 times to cover pointer wrap; the order must match the load order.
- Reset mid-operation: with 2 entries buffered and drop_err=1, pulse rst=0 asynchronously between clock edges -> res_valid, in_ready=1, drop_err=0 immediately. A subsequent load of 0x3F800000 emerges alone after 1 cycle.

Source files
------------

// File: rtl/mult_result_out_stage_if.sv
// Result stream from the multiplier output stage to its downstream consumer:
// valid/ready handshake carrying the packed IEEE word and its exception flags.
interface mult_result_out_stage_if #(
  parameter int W = 32
);
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         ovf_flag;
  logic         unf_flag;

  modport master (
    output res_valid,
    output result,
    output ovf_flag,
    output unf_flag,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  result,
    input  ovf_flag,
    input  unf_flag,
    output res_ready
  );
endinterface

// File: rtl/mult_result_out_stage.sv
// Multiplier output stage: packs sign/exponent/significand into an IEEE word with
// overflow/underflow substitution and drains a 2-entry buffer over valid/ready.
module mult_result_out_stage #(
  parameter int W  = 32,
  parameter int EW = 8,
  parameter int SW = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_res,
  input  logic                   sign_i,
  input  logic [EW-1:0]          exp_i,
  input  logic [SW-1:0]          sig_i,
  input  logic                   ovf_i,
  input  logic                   unf_i,
  output logic                   in_ready,
  output logic                   drop_err,
  mult_result_out_stage_if.master res
);

  typedef struct packed {
    logic         ovf;
    logic         unf;
    logic [W-1:0] word;
  } entry_t;

  entry_t       mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic [W-1:0] packed_word;
  logic         push;
  logic         pop;
  entry_t       head;

  // Overflow wins over underflow when both are reported.
  always_comb begin
    if (ovf_i)
      packed_word = {sign_i, {EW{1'b1}}, {SW{1'b0}}};
    else if (unf_i)
      packed_word = {sign_i, {(W-1){1'b0}}};
    else
      packed_word = {sign_i, exp_i, sig_i};
  end

  assign in_ready = (count != 2'd2);
  assign push     = load_res & in_ready;
  assign pop      = res.res_valid & res.res_ready;

  // NOTE: storage entries carry no reset; count/pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{ovf: ovf_i, unf: unf_i, word: packed_word};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      drop_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
      if (load_res && !in_ready) drop_err <= 1'b1;
    end
  end

  // Outputs are gated to zero while empty so stale entries never leak out.
  always_comb begin
    head          = mem[rd_ptr];
    res.res_valid = (count != 2'd0);
    res.result    = '0;
    res.ovf_flag  = 1'b0;
    res.unf_flag  = 1'b0;
    if (res.res_valid) begin
      res.result   = head.word;
      res.ovf_flag = head.ovf;
      res.unf_flag = head.unf;
    end
  end

endmodule

// File: tb/tb_mult_result_out_stage.sv
// Bench for mult_result_out_stage: queue model checked every cycle plus directed
// literal expectations for packing, backpressure, ordering and async reset.
module tb_mult_result_out_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_res = 1'b0;
  logic        sign_i = 1'b0;
  logic [7:0]  exp_i = '0;
  logic [22:0] sig_i = '0;
  logic        ovf_i = 1'b0;
  logic        unf_i = 1'b0;
  logic        in_ready;
  logic        drop_err;

  int checks = 0;
  int failures = 0;

  mult_result_out_stage_if #(.W(32)) res_if ();

  mult_result_out_stage #(.W(32), .EW(8), .SW(23)) dut (
    .clk      (clk),
    .rst      (rst),
    .load_res (load_res),
    .sign_i   (sign_i),
    .exp_i    (exp_i),
    .sig_i    (sig_i),
    .ovf_i    (ovf_i),
    .unf_i    (unf_i),
    .in_ready (in_ready),
    .drop_err (drop_err),
    .res      (res_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ovf;
    logic        unf;
    logic [31:0] word;
  } ent_t;

  ent_t q[$];
  logic m_drop = 1'b0;

  function automatic logic [31:0] pack_ieee(input logic s, input logic [7:0] e,
                                            input logic [22:0] f, input logic o,
                                            input logic u);
    longint unsigned v;
    if (o)      v = longint'(s) * 64'h8000_0000 + 64'h7F80_0000;
    else if (u) v = longint'(s) * 64'h8000_0000;
    else        v = longint'(s) * 64'h8000_0000 + longint'(e) * 64'h80_0000 + longint'(f);
    return v[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bounded queue updated from the same inputs at each edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_drop <= 1'b0;
    end else begin
      int n;
      n = q.size();
      if (load_res && n == 2) m_drop <= 1'b1;
      if (n > 0 && res_if.res_ready) void'(q.pop_front());
      if (load_res && n < 2)
        q.push_back('{ovf: ovf_i, unf: unf_i,
                      word: pack_ieee(sign_i, exp_i, sig_i, ovf_i, unf_i)});
    end
  end

  // Every-cycle comparison on the inactive edge.
  always @(negedge clk) begin
    if (rst) begin
      check("m_valid", res_if.res_valid, q.size() != 0);
      check("m_in_ready", in_ready, q.size() != 2);
      check("m_drop_err", drop_err, m_drop);
      if (q.size() != 0) begin
        check("m_result", res_if.result, q[0].word);
        check("m_ovf", res_if.ovf_flag, q[0].ovf);
        check("m_unf", res_if.unf_flag, q[0].unf);
      end else begin
        check("m_result_gated", res_if.result, 0);
        check("m_flags_gated", {res_if.ovf_flag, res_if.unf_flag}, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic s, input logic [7:0] e,
                       input logic [22:0] f, input logic o, input logic u);
    load_res = ld; sign_i = s; exp_i = e; sig_i = f; ovf_i = o; unf_i = u;
  endtask

  task automatic drive_word(input logic [31:0] w);
    drive(1'b1, w[31], w[30:23], w[22:0], 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h0, 23'h0, 1'b0, 1'b0);
  endtask

  task automatic expect_head(input string name, input logic v, input logic [31:0] w,
                             input logic o, input logic u);
    check({name, "_valid"}, res_if.res_valid, v);
    check({name, "_result"}, res_if.result, w);
    check({name, "_flags"}, {res_if.ovf_flag, res_if.unf_flag}, {o, u});
  endtask

  logic [31:0] seq [6];

  initial begin
    res_if.res_ready = 1'b0;
    #12;
    check("rst_valid", res_if.res_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", res_if.result, 0);
    check("rst_drop", drop_err, 0);
    rst = 1'b1;
    step();

    // Normal packing, 1-cycle latency then drained.
    res_if.res_ready = 1'b1;
    drive(1'b1, 1'b0, 8'h7F, 23'h400000, 1'b0, 1'b0);
    step();
    idle();
    expect_head("norm", 1'b1, 32'h3FC0_0000, 1'b0, 1'b0);
    step();
    expect_head("norm_drained", 1'b0, 32'h0, 1'b0, 1'b0);

    // Exception substitution.
    drive(1'b1, 1'b1, 8'h12, 23'h1, 1'b1, 1'b0);
    step();
    expect_head("ovf_neg", 1'b1, 32'hFF80_0000, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 8'h40, 23'h1234, 1'b0, 1'b1);
    step();
    expect_head("unf_neg", 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 8'h55, 23'h7FFFFF, 1'b1, 1'b1);
    step();
    idle();
    expect_head("ovf_unf", 1'b1, 32'h7F80_0000, 1'b1, 1'b1);
    step();

    // Backpressure, full, drop.
    res_if.res_ready = 1'b0;
    drive_word(32'h3F80_0000);
    step();
    drive_word(32'h4000_0000);
    step();
    check("full_in_ready", in_ready, 0);
    drive_word(32'h4040_0000);
    step();
    check("drop_set", drop_err, 1);
    expect_head("stall_a", 1'b1, 32'h3F80_0000, 1'b0, 1'b0);
    // Load while full and popping is still refused.
    res_if.res_ready = 1'b1;
    drive_word(32'h4080_0000);
    step();
    idle();
    expect_head("drain_b", 1'b1, 32'h4000_0000, 1'b0, 1'b0);
    check("after_pop_in_ready", in_ready, 1);
    step();
    expect_head("drain_empty", 1'b0, 32'h0, 1'b0, 1'b0);
    check("drop_sticky", drop_err, 1);

    // Simultaneous push/pop across pointer wrap.
    for (int i = 0; i < 6; i++) seq[i] = 32'h4100_0000 + 32'(i) * 32'h0010_0000;
    res_if.res_ready = 1'b0;
    drive_word(seq[0]);
    step();
    res_if.res_ready = 1'b1;
    for (int i = 1; i < 6; i++) begin
      expect_head($sformatf("pp_before%0d", i), 1'b1, seq[i-1], 1'b0, 1'b0);
      drive_word(seq[i]);
      step();
      check($sformatf("pp_in_ready%0d", i), in_ready, 1);
    end
    idle();
    expect_head("pp_last", 1'b1, seq[5], 1'b0, 1'b0);
    step();
    check("pp_empty", res_if.res_valid, 0);

    // Asynchronous reset mid-operation.
    res_if.res_ready = 1'b0;
    drive_word(32'h3F80_0000);
    step();
    drive_word(32'h4000_0000);
    step();
    drive_word(32'h4040_0000);
    step();
    idle();
    check("pre_rst_drop", drop_err, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", res_if.res_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_drop", drop_err, 0);
    check("arst_result", res_if.result, 0);
    #1 rst = 1'b1;
    step();
    res_if.res_ready = 1'b1;
    drive_word(32'h3F80_0000);
    step();
    idle();
    expect_head("post_rst", 1'b1, 32'h3F80_0000, 1'b0, 1'b0);
    step();
    expect_head("post_rst_alone", 1'b0, 32'h0, 1'b0, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
